// File: rtl/fetch_unit_pkg.sv
// fetch_pkg: shared widths, constants and queue entry type for the fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: redirect, instruction-memory and decode handshake signals of the fetch stage
interface fetch_unit_if;
  import fetch_pkg::*;
  logic redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic imem_gnt_i;
  logic imem_rvalid_i;
  logic [INST_W-1:0] imem_rdata_i;
  logic inst_valid_o;
  logic [INST_W-1:0] inst_o;
  logic [XLEN-1:0] inst_pc_o;
  logic inst_ready_i;
  modport master (
    input redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o
  );
  modport slave (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    input imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o
  );
endinterface

// File: rtl/fetch_unit_queue.sv
// fetch_queue: synchronous FIFO of {pc, inst} entries with flush; head reads as zero when empty
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CNTW = AW + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t data_o,
  output logic [CNTW-1:0] count_o,
  output logic empty_o
);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CNTW-1:0] count_q;
  logic do_push, do_pop;
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign data_o = empty_o ? '0 : mem_q[head_q];
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & ((count_q != FULL) | do_pop);
  // pointer/occupancy update; flush drops every entry at once
  always_ff @(posedge clk)
    if (rst || flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[tail_q] <= data_i;
        tail_q <= tail_q + AW'(1);
      end
      if (do_pop) head_q <= head_q + AW'(1);
      count_q <= count_q + CNTW'(do_push) - CNTW'(do_pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues credit-limited in-order fetches and queues {pc, inst} for decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(2 * DEPTH + 1);
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d;
  logic [XLEN-1:0] spc_q [DEPTH];
  logic [AW-1:0] swr_q, srd_q;
  fetch_entry_t head;
  logic [AW:0] occ;
  logic empty, pop, gnt, take, accept;
  assign pop = bus.inst_valid_o & bus.inst_ready_i;
  assign bus.imem_addr_o = word_align(pc_q);
  assign bus.imem_req_o = !rst && !bus.redirect_i && ((out_q + CW'(occ) - CW'(pop)) < CW'(DEPTH));
  assign gnt = bus.imem_req_o & bus.imem_gnt_i;
  assign take = bus.imem_rvalid_i & (drop_q == '0);
  assign accept = take & ~bus.redirect_i;
  assign bus.inst_valid_o = !rst && !empty;
  assign bus.inst_o = head.inst;
  assign bus.inst_pc_o = head.pc;
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .push_i(accept),
    .pop_i(pop),
    .flush_i(bus.redirect_i),
    .data_i('{pc: spc_q[srd_q], inst: bus.imem_rdata_i}),
    .data_o(head),
    .count_o(occ),
    .empty_o(empty)
  );
  // PCs of granted requests, retired in order as their responses are accepted
  always_ff @(posedge clk)
    if (rst || bus.redirect_i) begin
      swr_q <= '0;
      srd_q <= '0;
    end else begin
      if (gnt) begin
        spc_q[swr_q] <= bus.imem_addr_o;
        swr_q <= swr_q + AW'(1);
      end
      if (take) srd_q <= srd_q + AW'(1);
    end
  // next PC and in-flight/drop accounting; a redirect turns all in-flight requests into drops
  always_comb begin
    pc_d = bus.redirect_i ? word_align(bus.redirect_pc_i) : gnt ? pc_q + 32'd4 : pc_q;
    out_d = bus.redirect_i ? '0 : out_q + CW'(gnt) - CW'(take);
    drop_d = bus.redirect_i ? drop_q + out_q - CW'(bus.imem_rvalid_i)
                            : drop_q - CW'(bus.imem_rvalid_i & (drop_q != '0));
  end
  // state registers
  always_ff @(posedge clk)
    if (rst) begin
      pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q <= pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random traffic against an epoch-tagged stream model with a decoupled scoreboard
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  typedef struct {
    logic [31:0] addr;
    int due;
    int ep;
  } mem_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit resp;
    int rcyc;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  fetch_unit_if bus ();
  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  mem_t mem_q[$];
  exp_t expq[$];
  int n_chk = 0, n_fail = 0, cyc = 0, epoch = 0, delivered = 0;
  int p_gnt = 100, p_ready = 100, p_rv = 100, lat_min = 1, lat_max = 1, p_redir = 0;
  bit redir_req = 0;
  logic [31:0] redir_tgt = '0, model_pc = RST_PC;
  bit mvis, mpop, exp_req, found;
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // scoreboard: compares DUT outputs with the stream model each cycle, then advances the model
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req", 32'(bus.imem_req_o), 0);
      chk("rst_valid", 32'(bus.inst_valid_o), 0);
      expq.delete();
      mem_q.delete();
      epoch++;
      model_pc = RST_PC;
    end else begin
      mvis = expq.size() > 0 && expq[0].resp && expq[0].rcyc < cyc;
      chk("valid", 32'(bus.inst_valid_o), 32'(mvis));
      if (mvis) begin
        chk("inst_pc", bus.inst_pc_o, expq[0].pc);
        chk("inst", bus.inst_o, expq[0].inst);
      end else begin
        chk("empty_pc", bus.inst_pc_o, 0);
        chk("empty_inst", bus.inst_o, 0);
      end
      mpop = mvis && bus.inst_ready_i;
      exp_req = !bus.redirect_i && (expq.size() - int'(mpop) < DEPTH);
      chk("req", 32'(bus.imem_req_o), 32'(exp_req));
      if (bus.imem_req_o) chk("addr", bus.imem_addr_o, model_pc);
      if (mpop && !bus.redirect_i) begin
        void'(expq.pop_front());
        delivered++;
      end
      if (bus.imem_req_o && bus.imem_gnt_i) begin
        mem_q.push_back('{bus.imem_addr_o, cyc + $urandom_range(lat_min, lat_max), epoch});
        expq.push_back('{model_pc, inst_of(model_pc), 1'b0, 0});
        model_pc += 32'd4;
      end
      if (bus.imem_rvalid_i && mem_q.size() > 0) begin
        if (mem_q[0].ep == epoch && !bus.redirect_i) begin
          found = 0;
          foreach (expq[i])
            if (!found && !expq[i].resp) begin
              expq[i].resp = 1;
              expq[i].rcyc = cyc;
              found = 1;
            end
        end
        void'(mem_q.pop_front());
      end
      if (bus.redirect_i) begin
        epoch++;
        expq.delete();
        model_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
      end
      chk("inflight_bound", 32'(mem_q.size() <= 2 * DEPTH), 1);
    end
    cyc++;
  end
  task automatic drive_cycle(input logic rst_v);
    @(posedge clk);
    #2;
    rst = rst_v;
    bus.imem_gnt_i = $urandom_range(0, 99) < p_gnt;
    bus.inst_ready_i = $urandom_range(0, 99) < p_ready;
    bus.imem_rvalid_i = 0;
    bus.imem_rdata_i = '0;
    bus.redirect_i = 0;
    if (!rst_v && mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(0, 99) < p_rv) begin
      bus.imem_rvalid_i = 1;
      bus.imem_rdata_i = inst_of(mem_q[0].addr);
    end
    if (!rst_v && (redir_req || ($urandom_range(0, 999) < p_redir && mem_q.size() <= DEPTH))) begin
      bus.redirect_i = 1;
      bus.redirect_pc_i = redir_req ? redir_tgt
                        : ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                        : 32'($urandom_range(0, 32'hFFFF));
      redir_req = 0;
    end
  endtask
  task automatic run(input int n);
    repeat (n) drive_cycle(0);
  endtask
  task automatic redirect_to(input logic [31:0] t);
    redir_tgt = t;
    redir_req = 1;
    run(1);
  endtask
  task automatic knobs(input int g, input int r, input int v, input int lmin, input int lmax, input int rd);
    p_gnt = g; p_ready = r; p_rv = v; lat_min = lmin; lat_max = lmax; p_redir = rd;
  endtask
  initial begin
    bus.redirect_i = 0;
    bus.redirect_pc_i = '0;
    bus.imem_gnt_i = 0;
    bus.imem_rvalid_i = 0;
    bus.imem_rdata_i = '0;
    bus.inst_ready_i = 0;
    repeat (3) drive_cycle(1);
    knobs(100, 100, 100, 1, 1, 0);
    run(20);
    knobs(100, 0, 100, 1, 1, 0);
    run(10);
    knobs(100, 100, 100, 1, 1, 0);
    run(10);
    knobs(0, 100, 100, 1, 1, 0);
    run(3);
    knobs(100, 100, 100, 1, 1, 0);
    run(5);
    knobs(100, 0, 100, 2, 2, 0);
    run(3);
    redirect_to(32'h0000_0100);
    knobs(100, 100, 100, 2, 2, 0);
    run(12);
    knobs(100, 100, 100, 1, 1, 0);
    redirect_to(32'h0000_0202);
    run(10);
    redirect_to(32'hFFFF_FFF4);
    run(10);
    redirect_to(32'h0000_0040);
    redirect_to(32'h0000_0080);
    run(10);
    knobs(70, 60, 70, 1, 4, 30);
    run(1500);
    repeat (2) drive_cycle(1);
    knobs(80, 80, 80, 1, 3, 20);
    run(1500);
    knobs(100, 100, 100, 1, 1, 0);
    run(20);
    chk("progress", 32'(delivered > 500), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
